evm_vote_tally: RTL and testbench

EVM_VOTE_TALLY -- requirements
Module: evm_vote_tally

---
 rtl/evm_vote_tally.sv | 218 +++++++++++++++++++++
 tb/tb_evm_vote_tally.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_vote_tally.sv
// Electronic voting machine tally block.
//
// A voter selects one candidate with a one-hot vote_sel. The selection is held
// pending until confirm_vote commits it or cancel_vote discards it. If neither
// arrives, the selection expires after TIMEOUT idle cycles. Each candidate has
// a saturating counter. The leader, max flags and tie are derived combinationally
// from those counters.
//
// Ports:
//   clk, reset     rising-edge clock; synchronous active-high reset
//   enable_vote    voting session open; dropping it aborts any selection
//   vote_sel       one-hot candidate select (level sampled)
//   confirm_vote   commit the pending selection
//   cancel_vote    discard the pending selection
//   votes          packed counters, candidate i at [i*CNT_W +: CNT_W]
//   max_votes      per-candidate "holds the highest count" flags
//   winner         lowest index among the leaders
//   tie            more than one leader
//   pending        a selection is awaiting confirm
//   vote_accepted  one-cycle pulse: a vote was counted
//   vote_error     one-cycle pulse: multi-hot select or confirm to a full counter
//   vote_timeout   one-cycle pulse: pending selection expired
module evm_vote_tally #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 7,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable_vote,
  input  logic [NUM_CAND-1:0]         vote_sel,
  input  logic                        confirm_vote,
  input  logic                        cancel_vote,
  output logic [NUM_CAND*CNT_W-1:0]   votes,
  output logic [NUM_CAND-1:0]         max_votes,
  output logic [$clog2(NUM_CAND)-1:0] winner,
  output logic                        tie,
  output logic                        pending,
  output logic                        vote_accepted,
  output logic                        vote_error,
  output logic                        vote_timeout
);

  localparam int unsigned    IdxW      = $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [7:0]     TimerLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReady, StSelected} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  sel_idx_q, sel_idx_d;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q [NUM_CAND];
  logic [CNT_W-1:0] cnt_d [NUM_CAND];
  logic             accepted_q, accepted_d;
  logic             error_q, error_d;
  logic             timeout_q, timeout_d;

  // Decode of the raw select lines.
  logic [4:0]       sel_cnt;
  logic [IdxW-1:0]  sel_idx;
  logic [CNT_W-1:0] pend_cnt;
  logic             inc;

  always_comb begin
    sel_cnt  = '0;
    sel_idx  = '0;
    pend_cnt = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      sel_cnt = sel_cnt + 5'(vote_sel[i]);
      if (vote_sel[i]) begin
        sel_idx = IdxW'(i);
      end
      if (sel_idx_q == IdxW'(i)) begin
        pend_cnt = cnt_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    timer_d    = timer_q;
    accepted_d = 1'b0;
    error_d    = 1'b0;
    timeout_d  = 1'b0;
    inc        = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable_vote) begin
          state_d = StReady;
        end
      end

      StReady: begin
        if (!enable_vote) begin
          state_d = StIdle;
        end else if (sel_cnt == 5'd1) begin
          sel_idx_d = sel_idx;
          timer_d   = '0;
          state_d   = StSelected;
        end else if (sel_cnt > 5'd1) begin
          error_d = 1'b1;
        end
      end

      StSelected: begin
        if (!enable_vote) begin
          state_d   = StIdle;
          sel_idx_d = '0;
          timer_d   = '0;
        end else if (cancel_vote) begin
          state_d = StReady;
        end else if (confirm_vote) begin
          state_d = StReady;
          if (pend_cnt == CntMax) begin
            error_d = 1'b1;
          end else begin
            inc        = 1'b1;
            accepted_d = 1'b1;
          end
        end else if (sel_cnt == 5'd1) begin
          sel_idx_d = sel_idx;
          timer_d   = '0;
        end else if (sel_cnt > 5'd1) begin
          // Error outranks expiry; the timer keeps running but is held at its
          // last value so the expiry fires on the next quiet cycle.
          error_d = 1'b1;
          if (timer_q < TimerLast) begin
            timer_d = timer_q + 8'd1;
          end
        end else if (timer_q >= TimerLast) begin
          timeout_d = 1'b1;
          state_d   = StReady;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc && (sel_idx_q == IdxW'(i))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_idx_q  <= '0;
      timer_q    <= '0;
      cnt_q      <= '{default: '0};
      accepted_q <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      accepted_q <= accepted_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pending       = (state_q == StSelected);
  assign vote_accepted = accepted_q;
  assign vote_error    = error_q;
  assign vote_timeout  = timeout_q;

  always_comb begin
    votes = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      votes[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // Leader flags. An all-zero tally has no leader.
  logic [CNT_W-1:0] max_val;
  logic [4:0]       n_max;
  logic             found;

  always_comb begin
    max_val = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (cnt_q[i] > max_val) begin
        max_val = cnt_q[i];
      end
    end

    max_votes = '0;
    winner    = '0;
    n_max     = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if ((max_val != '0) && (cnt_q[i] == max_val)) begin
        max_votes[i] = 1'b1;
        n_max        = n_max + 5'd1;
        if (!found) begin
          winner = IdxW'(i);
          found  = 1'b1;
        end
      end
    end
    tie = (n_max > 5'd1);
  end

endmodule

// File: tb/tb_evm_vote_tally.sv
module tb_evm_vote_tally;

  localparam int NC = 4;
  localparam int CW = 7;

  localparam int KAcc = 0;
  localparam int KErr = 1;
  localparam int KTo  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable_vote;
  logic [NC-1:0]    vote_sel;
  logic             confirm_vote;
  logic             cancel_vote;
  logic [NC*CW-1:0] votes;
  logic [NC-1:0]    max_votes;
  logic [1:0]       winner;
  logic             tie;
  logic             pending;
  logic             vote_accepted;
  logic             vote_error;
  logic             vote_timeout;

  evm_vote_tally #(
    .NUM_CAND(4),
    .CNT_W   (7),
    .TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_vote  (enable_vote),
    .vote_sel     (vote_sel),
    .confirm_vote (confirm_vote),
    .cancel_vote  (cancel_vote),
    .votes        (votes),
    .max_votes    (max_votes),
    .winner       (winner),
    .tie          (tie),
    .pending      (pending),
    .vote_accepted(vote_accepted),
    .vote_error   (vote_error),
    .vote_timeout (vote_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [27:0] votes;
    logic [3:0]  maxv;
    logic [1:0]  win;
    logic        tie;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_ev(input int kind, input logic [27:0] v, input logic [3:0] mv,
                           input logic [1:0] w, input logic t);
    ev_t e;
    e.kind  = kind;
    e.votes = v;
    e.maxv  = mv;
    e.win   = w;
    e.tie   = t;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse is matched against the oldest expected event.
  always @(negedge clk) begin
    if (vote_accepted || vote_error || vote_timeout) begin
      check("pulse_excl", 64'($countones({vote_accepted, vote_error, vote_timeout})), 64'd1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {61'd0, vote_accepted, vote_error, vote_timeout}, 64'd0);
      end else begin
        ev_t e;
        int  k;
        e = sb.pop_front();
        k = vote_accepted ? KAcc : (vote_error ? KErr : KTo);
        check("pulse_kind", 64'(k), 64'(e.kind));
        check("ev_votes", 64'(votes), 64'(e.votes));
        check("ev_max_votes", 64'(max_votes), 64'(e.maxv));
        check("ev_winner", 64'(winner), 64'(e.win));
        check("ev_tie", 64'(tie), 64'(e.tie));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    enable_vote  = 1'b0;
    vote_sel     = '0;
    confirm_vote = 1'b0;
    cancel_vote  = 1'b0;
    tick(2);
    check("rst_votes", 64'(votes), 64'd0);
    check("rst_max", 64'(max_votes), 64'd0);
    check("rst_winner", 64'(winner), 64'd0);
    check("rst_tie", 64'(tie), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);

    reset       = 1'b0;
    enable_vote = 1'b1;
    tick(1);
    check("ready_not_pending", 64'(pending), 64'd0);

    // Basic count: select, release, confirm two cycles later.
    vote_sel = 4'b0001;
    tick(1);
    check("sel_pending", 64'(pending), 64'd1);
    vote_sel = 4'b0000;
    tick(2);
    check("sel_latched", 64'(pending), 64'd1);
    confirm_vote = 1'b1;
    expect_ev(KAcc, 28'h0000001, 4'b0001, 2'd0, 1'b0);
    tick(1);
    confirm_vote = 1'b0;
    check("post_confirm_pending", 64'(pending), 64'd0);
    tick(1);

    // Cancel discards; then a real vote for candidate 1 makes a tie.
    vote_sel = 4'b0010;
    tick(1);
    vote_sel    = 4'b0000;
    cancel_vote = 1'b1;
    tick(1);
    cancel_vote = 1'b0;
    check("cancel_votes", 64'(votes), 64'h1);
    check("cancel_pending", 64'(pending), 64'd0);
    vote_sel = 4'b0010;
    tick(1);
    vote_sel     = 4'b0000;
    confirm_vote = 1'b1;
    expect_ev(KAcc, 28'h0000081, 4'b0011, 2'd0, 1'b1);
    tick(1);
    confirm_vote = 1'b0;
    tick(1);

    // Timeout after exactly 16 quiet cycles.
    vote_sel = 4'b0100;
    tick(1);
    vote_sel = 4'b0000;
    expect_ev(KTo, 28'h0000081, 4'b0011, 2'd0, 1'b1);
    tick(15);
    check("no_early_timeout", 64'(pending), 64'd1);
    tick(1);
    check("timeout_pending", 64'(pending), 64'd0);
    tick(1);

    // Reselect moves the vote from candidate 2 to 3.
    vote_sel = 4'b0100;
    tick(1);
    vote_sel = 4'b1000;
    tick(1);
    vote_sel     = 4'b0000;
    confirm_vote = 1'b1;
    expect_ev(KAcc, 28'h0200081, 4'b1011, 2'd0, 1'b1);
    tick(1);
    confirm_vote = 1'b0;
    tick(1);

    // Multi-hot in READY: error, stay READY.
    vote_sel = 4'b0110;
    expect_ev(KErr, 28'h0200081, 4'b1011, 2'd0, 1'b1);
    tick(1);
    vote_sel = 4'b0000;
    check("multihot_ready", 64'(pending), 64'd0);
    tick(1);
    vote_sel = 4'b0001;
    tick(1);
    vote_sel = 4'b0000;
    check("still_ready", 64'(pending), 64'd1);
    // Cancel beats confirm.
    confirm_vote = 1'b1;
    cancel_vote  = 1'b1;
    tick(1);
    confirm_vote = 1'b0;
    cancel_vote  = 1'b0;
    check("cancel_wins_pending", 64'(pending), 64'd0);
    check("cancel_wins_votes", 64'(votes), 64'h0200081);
    tick(1);

    // Multi-hot while SELECTED keeps the existing selection.
    vote_sel = 4'b0100;
    tick(1);
    vote_sel = 4'b0011;
    expect_ev(KErr, 28'h0200081, 4'b1011, 2'd0, 1'b1);
    tick(1);
    vote_sel     = 4'b0000;
    confirm_vote = 1'b1;
    expect_ev(KAcc, 28'h0204081, 4'b1111, 2'd0, 1'b1);
    tick(1);
    confirm_vote = 1'b0;
    tick(1);

    // Drive candidate 0 to saturation, then confirm once more.
    for (int i = 2; i <= 127; i++) begin
      vote_sel = 4'b0001;
      tick(1);
      vote_sel     = 4'b0000;
      confirm_vote = 1'b1;
      expect_ev(KAcc, 28'h0204080 | 28'(i), 4'b0001, 2'd0, 1'b0);
      tick(1);
      confirm_vote = 1'b0;
    end
    vote_sel = 4'b0001;
    tick(1);
    vote_sel     = 4'b0000;
    confirm_vote = 1'b1;
    expect_ev(KErr, 28'h02040FF, 4'b0001, 2'd0, 1'b0);
    tick(1);
    confirm_vote = 1'b0;
    check("sat_votes", 64'(votes), 64'h02040FF);
    tick(1);

    // Session closed mid-selection: no count, later confirms ignored.
    vote_sel = 4'b0010;
    tick(1);
    vote_sel    = 4'b0000;
    enable_vote = 1'b0;
    tick(1);
    check("disable_pending", 64'(pending), 64'd0);
    confirm_vote = 1'b1;
    tick(1);
    confirm_vote = 1'b0;
    check("idle_confirm_votes", 64'(votes), 64'h02040FF);
    enable_vote = 1'b1;
    tick(1);
    confirm_vote = 1'b1;
    tick(1);
    confirm_vote = 1'b0;
    check("ready_confirm_votes", 64'(votes), 64'h02040FF);

    // Reset beats a simultaneous confirm.
    vote_sel = 4'b0010;
    tick(1);
    vote_sel     = 4'b0000;
    confirm_vote = 1'b1;
    reset        = 1'b1;
    tick(1);
    reset        = 1'b0;
    confirm_vote = 1'b0;
    check("rst2_votes", 64'(votes), 64'd0);
    check("rst2_max", 64'(max_votes), 64'd0);
    check("rst2_winner", 64'(winner), 64'd0);
    check("rst2_tie", 64'(tie), 64'd0);
    check("rst2_pending", 64'(pending), 64'd0);
    tick(3);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
